// File: rtl/mem_stage.sv
// Memory-access stage: data-memory request/ack handshake, upstream stall, branch resolve, MEM/WB register.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT timeout counter and sticky MEM_ERROR flag.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] ALU_VAL_IN,
  input  logic [63:0] RT_READ_IN,
  input  logic [63:0] BRANCH_IN,
  input  logic        ZERO_IN,
  input  logic [4:0]  REG_DESTINATION_IN,
  input  logic        REGWRITE_IN,
  input  logic        MEM2REG_IN,
  input  logic        MEMWRITE_IN,
  input  logic        MEMREAD_IN,
  input  logic        BRANCH_ZERO_IN,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [63:0] DMEM_ADDR,
  output logic [63:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [63:0] DMEM_RDATA,
  output logic        STALL,
  output logic        PCSRC,
  output logic [63:0] BRANCH_TARGET_OUT,
  output logic [63:0] READ_DATA_OUT,
  output logic [63:0] ALU_VAL_OUT,
  output logic [4:0]  REG_DESTINATION_OUT,
  output logic        REGWRITE_OUT,
  output logic        MEM2REG_OUT,
  output logic        MEM_ERROR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        w_memop;
  logic        w_busy;
  logic        w_tmo;
  logic        w_drop_wb;
  logic [63:0] r_rdata;
  logic [63:0] r_read;
  logic [63:0] r_alu;
  logic [4:0]  r_dst;
  logic        r_regw;
  logic        r_m2r;

  assign w_memop = MEMREAD_IN | MEMWRITE_IN;
  // Gated by RESET so the handshake drops immediately on an async reset
  assign w_busy  = RESET & (((r_state == S_IDLE) & w_memop) | (r_state == S_WAIT));

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_tmo;
  logic          r_err;

  assign w_tmo = w_busy & (r_state == S_WAIT) & ~DMEM_ACK & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_cnt <= '0;
      else if (!DMEM_ACK) r_cnt <= r_cnt + CW'(1);
      if (w_tmo) begin
        r_tmo <= 1'b1;
        r_err <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_tmo <= 1'b0;
      end
    end
  end

  assign w_drop_wb = r_tmo;
  assign MEM_ERROR = r_err;
`else
  assign w_tmo     = 1'b0;
  assign w_drop_wb = 1'b0;
  assign MEM_ERROR = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_memop) w_next = DMEM_ACK ? S_DONE : S_WAIT;
      S_WAIT:  if (DMEM_ACK || w_tmo) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      // A combined read+write is treated as a write, so its load data is zero
      if (w_busy && DMEM_ACK) r_rdata <= MEMWRITE_IN ? '0 : DMEM_RDATA;
      else if (w_tmo)         r_rdata <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_read <= '0;
      r_alu  <= '0;
      r_dst  <= '0;
      r_regw <= 1'b0;
      r_m2r  <= 1'b0;
    end else if (w_busy) begin
      r_regw <= 1'b0;
      r_m2r  <= 1'b0;
    end else begin
      r_read <= (r_state == S_DONE) ? r_rdata : '0;
      r_alu  <= ALU_VAL_IN;
      r_dst  <= REG_DESTINATION_IN;
      r_regw <= REGWRITE_IN & ~w_drop_wb;
      r_m2r  <= MEM2REG_IN;
    end
  end

  assign DMEM_REQ            = w_busy;
  assign STALL               = w_busy;
  assign DMEM_WE             = w_busy & MEMWRITE_IN;
  assign DMEM_ADDR           = ALU_VAL_IN;
  assign DMEM_WDATA          = RT_READ_IN;
  assign PCSRC               = RESET & BRANCH_ZERO_IN & ZERO_IN & ~w_busy;
  assign BRANCH_TARGET_OUT   = BRANCH_IN;
  assign READ_DATA_OUT       = r_read;
  assign ALU_VAL_OUT         = r_alu;
  assign REG_DESTINATION_OUT = r_dst;
  assign REGWRITE_OUT        = r_regw;
  assign MEM2REG_OUT         = r_m2r;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, random instruction stream, reset and timeout sequences.
module tb_mem_stage;

  localparam int unsigned TB_TO =
`ifdef MEM_TIMEOUT_EN
    4;
`else
    255;
`endif
  localparam int unsigned NO_ACK = 99;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] ALU_VAL_IN, RT_READ_IN, BRANCH_IN, DMEM_RDATA;
  logic        ZERO_IN, REGWRITE_IN, MEM2REG_IN, MEMWRITE_IN, MEMREAD_IN, BRANCH_ZERO_IN, DMEM_ACK;
  logic [4:0]  REG_DESTINATION_IN;
  logic        DMEM_REQ, DMEM_WE, STALL, PCSRC, REGWRITE_OUT, MEM2REG_OUT, MEM_ERROR;
  logic [63:0] DMEM_ADDR, DMEM_WDATA, BRANCH_TARGET_OUT, READ_DATA_OUT, ALU_VAL_OUT;
  logic [4:0]  REG_DESTINATION_OUT;

  mem_stage #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .CLK(CLK), .RESET(RESET), .ALU_VAL_IN(ALU_VAL_IN), .RT_READ_IN(RT_READ_IN),
    .BRANCH_IN(BRANCH_IN), .ZERO_IN(ZERO_IN), .REG_DESTINATION_IN(REG_DESTINATION_IN),
    .REGWRITE_IN(REGWRITE_IN), .MEM2REG_IN(MEM2REG_IN), .MEMWRITE_IN(MEMWRITE_IN),
    .MEMREAD_IN(MEMREAD_IN), .BRANCH_ZERO_IN(BRANCH_ZERO_IN), .DMEM_REQ(DMEM_REQ),
    .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK),
    .DMEM_RDATA(DMEM_RDATA), .STALL(STALL), .PCSRC(PCSRC), .BRANCH_TARGET_OUT(BRANCH_TARGET_OUT),
    .READ_DATA_OUT(READ_DATA_OUT), .ALU_VAL_OUT(ALU_VAL_OUT),
    .REG_DESTINATION_OUT(REG_DESTINATION_OUT), .REGWRITE_OUT(REGWRITE_OUT),
    .MEM2REG_OUT(MEM2REG_OUT), .MEM_ERROR(MEM_ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd, wr, regw, m2r, bz, zero;
    logic [63:0] alu, rt, br, rdata;
    logic [4:0]  dst;
    int unsigned delay;      // request-cycle index carrying the ACK (NO_ACK = never)
    int unsigned e_stall;    // expected stall cycles
    logic [63:0] e_read;
    logic        e_regw, e_pcsrc;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] p_alu  = '0;
  logic [63:0] p_read = '0;
  logic [4:0]  p_dst  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, regw, m2r, bz, zero,
                              input logic [63:0] alu, rt, br, rdata, input logic [4:0] dst,
                              input int unsigned delay, e_stall, input logic [63:0] e_read,
                              input logic e_regw, e_pcsrc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.regw = regw; v.m2r = m2r; v.bz = bz; v.zero = zero;
    v.alu = alu; v.rt = rt; v.br = br; v.rdata = rdata; v.dst = dst;
    v.delay = delay; v.e_stall = e_stall; v.e_read = e_read; v.e_regw = e_regw; v.e_pcsrc = e_pcsrc;
    return v;
  endfunction

  // Reference model at instruction level: stall length, load result and branch decision
  function automatic vec_t rand_vec();
    vec_t v;
    logic memop;
    v = mk($urandom_range(0, 1) == 1 && $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           5'($urandom), $urandom_range(0, 3), 0, '0, 1'b0, 1'b0);
    memop     = v.rd | v.wr;
    v.e_stall = memop ? v.delay + 1 : 0;
    v.e_read  = (memop && !v.wr) ? v.rdata : 64'd0;
    v.e_regw  = v.regw;
    v.e_pcsrc = v.bz & v.zero;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    MEMREAD_IN = v.rd; MEMWRITE_IN = v.wr; REGWRITE_IN = v.regw; MEM2REG_IN = v.m2r;
    BRANCH_ZERO_IN = v.bz; ZERO_IN = v.zero; ALU_VAL_IN = v.alu; RT_READ_IN = v.rt;
    BRANCH_IN = v.br; REG_DESTINATION_IN = v.dst;
  endtask

  // Entered and left at posedge+1
  task automatic run_vec(input vec_t v);
    drive(v);
    for (int unsigned c = 0; c < v.e_stall; c++) begin
      DMEM_ACK   = (c == v.delay);
      DMEM_RDATA = (c == v.delay) ? v.rdata : {$urandom, $urandom};
      @(negedge CLK);
      chk("stall", STALL, 1);
      chk("req", DMEM_REQ, 1);
      chk("we", DMEM_WE, v.wr);
      chk("addr", DMEM_ADDR, v.alu);
      chk("wdata", DMEM_WDATA, v.rt);
      chk("pcsrc_stall", PCSRC, 0);
      chk("btarget", BRANCH_TARGET_OUT, v.br);
      @(posedge CLK); #1;
      chk("bubble_regw", REGWRITE_OUT, 0);
      chk("bubble_m2r", MEM2REG_OUT, 0);
      chk("hold_alu", ALU_VAL_OUT, p_alu);
      chk("hold_dst", REG_DESTINATION_OUT, p_dst);
      chk("hold_read", READ_DATA_OUT, p_read);
    end
    DMEM_ACK   = 1'($urandom);
    DMEM_RDATA = {$urandom, $urandom};
    @(negedge CLK);
    chk("stall_final", STALL, 0);
    chk("req_final", DMEM_REQ, 0);
    chk("we_final", DMEM_WE, 0);
    chk("pcsrc", PCSRC, v.e_pcsrc);
    chk("btarget", BRANCH_TARGET_OUT, v.br);
    @(posedge CLK); #1;
    chk("wb_read", READ_DATA_OUT, v.e_read);
    chk("wb_regw", REGWRITE_OUT, v.e_regw);
    chk("wb_m2r", MEM2REG_OUT, v.m2r);
    chk("wb_alu", ALU_VAL_OUT, v.alu);
    chk("wb_dst", REG_DESTINATION_OUT, v.dst);
    p_alu = v.alu; p_dst = v.dst; p_read = v.e_read;
  endtask

  vec_t tbl[8];
  vec_t nop;

  initial begin
    tbl[0] = mk(0,0,1,0,0,0, 64'h11, 64'h0, 64'h0, 64'h0, 5'd3, 0, 0, 64'h0, 1, 0);
    tbl[1] = mk(0,0,1,0,0,0, 64'h22, 64'h0, 64'h0, 64'h0, 5'd4, 0, 0, 64'h0, 1, 0);
    tbl[2] = mk(1,0,1,1,0,0, 64'h100, 64'h0, 64'h0, 64'hDEADBEEF, 5'd5, 0, 1, 64'hDEADBEEF, 1, 0);
    tbl[3] = mk(0,1,0,0,0,0, 64'h200, 64'h55, 64'h0, 64'h0, 5'd0, 3, 4, 64'h0, 0, 0);
    tbl[4] = mk(0,0,0,0,1,1, 64'h0, 64'h0, 64'h40, 64'h0, 5'd0, 0, 0, 64'h0, 0, 1);
    tbl[5] = mk(0,0,0,0,1,0, 64'h0, 64'h0, 64'h40, 64'h0, 5'd0, 0, 0, 64'h0, 0, 0);
    tbl[6] = mk(1,1,1,1,0,0, 64'h300, 64'h77, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 1, 2, 64'h0, 1, 0);
    tbl[7] = mk(1,0,1,1,1,1, 64'h308, 64'h0, 64'h80, 64'h1234, 5'd7, 2, 3, 64'h1234, 1, 1);
    nop    = mk(0,0,0,0,0,0, 64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 0, 0, 64'h0, 0, 0);

    RESET = 1'b0; DMEM_ACK = 1'b1; DMEM_RDATA = '1;
    drive(tbl[7]);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req", DMEM_REQ, 0);
    chk("rst_stall", STALL, 0);
    chk("rst_pcsrc", PCSRC, 0);
    chk("rst_read", READ_DATA_OUT, 0);
    chk("rst_alu", ALU_VAL_OUT, 0);
    chk("rst_regw", REGWRITE_OUT, 0);
    chk("rst_err", MEM_ERROR, 0);
    drive(nop); DMEM_ACK = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset asserted mid-WAIT, then a late ACK that must be ignored
    drive(mk(1,0,1,1,1,1, 64'h400, 64'h0, 64'h0, 64'h0, 5'd9, 0, 0, 64'h0, 0, 0));
    DMEM_ACK = 1'b0;
    @(negedge CLK);
    chk("mid_req_idle", DMEM_REQ, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mid_req_wait", DMEM_REQ, 1);
    #1 RESET = 1'b0;
    #1;
    chk("mid_rst_req", DMEM_REQ, 0);
    chk("mid_rst_stall", STALL, 0);
    chk("mid_rst_pcsrc", PCSRC, 0);
    chk("mid_rst_alu", ALU_VAL_OUT, 0);
    chk("mid_rst_dst", REG_DESTINATION_OUT, 0);
    chk("mid_rst_read", READ_DATA_OUT, 0);
    drive(nop); DMEM_ACK = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("post_rst_req", DMEM_REQ, 0);
    chk("post_rst_stall", STALL, 0);
    @(posedge CLK); #1;
    chk("post_rst_read", READ_DATA_OUT, 0);
    chk("post_rst_regw", REGWRITE_OUT, 0);
    p_alu = '0; p_dst = '0; p_read = '0;
    DMEM_ACK = 1'b0;

    for (int n = 0; n < 200; n++) run_vec(rand_vec());

`ifdef MEM_TIMEOUT_EN
    run_vec(mk(1,0,1,1,0,0, 64'h500, 64'h0, 64'h0, 64'hABCD, 5'd8, NO_ACK, 5, 64'h0, 0, 0));
    chk("tmo_err", MEM_ERROR, 1);
    run_vec(tbl[0]);
    chk("tmo_err_sticky", MEM_ERROR, 1);
`else
    chk("err_tied", MEM_ERROR, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
